gpmc_sync_master: RTL
=====================

// Module: gpmc_sync_master
// PURPOSE
//  FPGA-side initiator for the synchronous multiplexed 16-bit GPMC bus (AD[15:0], ADVn, CSn, WEn, OEn, CLK).
//  Turns single host requests (valid/ready) into complete GPMC read/write cycles and returns read data.
//  Used to drive the gpmc_sync responder board-to-board and as the in-fabric bus driver in loopback benches.
// PARAMETERS
//  ADDR_WIDTH     16  request address width; must be <= 16 (zero-extended onto AD)
//  DATA_WIDTH     16  data width; must be <= 16
//  CLK_DIV        1   gpmc_clk half-period in clk cycles (gpmc_clk = clk/(2*CLK_DIV)); >=1
//  ADDR_CYCLES    1   gpmc_clk periods with ADVn low (address phase); >=1
//  ACCESS_CYCLES  6   gpmc_clk periods of WEn/OEn low; >=3 (covers responder 2-flop sync + register)
//  TURN_CYCLES    1   gpmc_clk periods with CSn high after each cycle; >=1
// PORTS
//  clk          in   1           system clock
//  rst_n        in   1           asynchronous active-low reset
//  req_valid    in   1           host request present
//  req_ready    out  1           block idle, request accepted when valid&ready
//  req_we       in   1           1=write, 0=read
//  req_addr     in   ADDR_WIDTH  target address
//  req_wdata    in   DATA_WIDTH  write data
//  resp_valid   out  1           one-clk pulse: cycle finished
//  resp_we      out  1           echo of req_we for the finished cycle
//  resp_rdata   out  DATA_WIDTH  read data, held until next read completes
//  gpmc_clk     out  1           bus clock, free-running after reset
//  gpmc_csn     out  1           chip select, active low
//  gpmc_advn    out  1           address valid, active low
//  gpmc_wein    out  1           write enable, active low
//  gpmc_oen     out  1           output enable, active low
//  gpmc_ad_out  out  16          AD drive value (SB_IO D_OUT_0 at top level)
//  gpmc_ad_oe   out  1           AD drive enable (SB_IO OUTPUT_ENABLE)
//  gpmc_ad_in   in   16          AD pad value (SB_IO D_IN_0)
// BEHAVIOUR
//  Reset (async, rst_n=0): gpmc_clk=0, csn/advn/wein/oen=1, ad_oe=0, ad_out=0, req_ready=0,
//   resp_valid=0, resp_we=0, resp_rdata=0, state=IDLE. First clk after release: req_ready=1.
//  Clocking: divider toggles gpmc_clk every CLK_DIV clks. "rise tick" = clk edge setting gpmc_clk=1.
//   All bus outputs change only on rise ticks; responder samples on gpmc_clk falling edge (mid-period).
//  States: IDLE -> ADDR -> [RTURN, reads only] -> ACCESS -> TURN -> IDLE; each transition on a rise tick.
//  IDLE: req_ready=1; on valid&ready latch we/addr/wdata, req_ready=0 same edge; wait next rise tick.
//  ADDR (ADDR_CYCLES): csn=0, advn=0, wein=oen=1, ad_oe=1, ad_out=addr.
//  RTURN (read, 1 period): advn=1, ad_oe=0, oen=1 -- dead cycle, no AD contention.
//  ACCESS (ACCESS_CYCLES): advn=1; write: wein=0, ad_oe=1, ad_out=wdata; read: oen=0, ad_oe=0.
//  End of ACCESS (rise tick entering TURN): read -> resp_rdata<=gpmc_ad_in[DATA_WIDTH-1:0];
//   resp_valid=1 for exactly one clk (both reads and writes), resp_we=latched we.
//  TURN (TURN_CYCLES): csn=wein=oen=advn=1, ad_oe=0; then IDLE, req_ready=1 on the next clk.
//  Phase counter counts rise ticks; width $clog2(max cycles)+1; no wrap within a phase.
//  req_valid while busy: ignored (ready=0), request must be held by host. Back-to-back requests:
//   min cycle = ADDR+ACCESS+TURN(+1 read) gpmc periods plus <=1 period alignment.
//  Reset mid-cycle: bus released immediately (csn=1, ad_oe=0), no resp_valid, transaction lost.
//  Invariant: ad_oe=1 never coincides with oen=0; wein and oen never both 0.
// STRUCTURE
//  gpmc_defs.vh: state encodings (IDLE,ADDR,RTURN,ACCESS,TURN), AD width 16, default timing localparams.
//  Sub-module gpmc_clk_div: CLK_DIV divider producing gpmc_clk and rise_tick/fall_tick strobes.
//  Top level owns the SB_IO (PIN_TYPE 6'b1010_01) tri-state; this block stays pad-free.
// TESTING
//  Reset: rst_n=0 mid-sim -> all outputs at reset values within same clk; req_ready=1 one clk after release.
//  Write addr=16'h0012 data=16'hBEEF, defaults -> AD=0012 with advn=0 for 1 period, wein=0 6 periods
//   with AD=BEEF, csn high 1 period; responder RAM word 0x12 == BEEF; resp_valid 1 clk, resp_we=1.
//  Read addr=16'h0012 against responder -> RTURN period with ad_oe=0, oen=1; resp_rdata=BEEF, resp_we=0.
//  Back-to-back: req_valid held high for 3 writes (0x1/0x2/0x3) -> 3 bus cycles, csn high >=1 period between.
//  CLK_DIV=3, ACCESS_CYCLES=3: gpmc_clk period=6 clk; read returns correct data; phase lengths exact.
//  Assertion run: random traffic 1000 txns -> no ad_oe&!oen, no !wein&!oen, AD stable across each fall edge.

Source files
------------

// File: rtl/gpmc_sync_master_pkg.sv
// Shared definitions for the synchronous multiplexed GPMC initiator.
//   - gpmc_state_e : bus cycle phases
//   - gpmc_ctrl_t  : bundle of the active-low bus strobes plus the AD drive enable
//   - AD_WIDTH     : width of the multiplexed address/data bus
//   - DEF_*        : default bus timing, in gpmc_clk periods (clk divider in clk cycles)
//   - max2()       : helper for sizing the phase counter
package gpmc_sync_master_pkg;

    localparam int AD_WIDTH          = 16;
    localparam int DEF_CLK_DIV       = 1;
    localparam int DEF_ADDR_CYCLES   = 1;
    localparam int DEF_ACCESS_CYCLES = 6;
    localparam int DEF_TURN_CYCLES   = 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_RTURN  = 3'd2,
        ST_ACCESS = 3'd3,
        ST_TURN   = 3'd4
    } gpmc_state_e;

    typedef struct packed {
        logic csn;
        logic advn;
        logic wein;
        logic oen;
        logic ad_oe;
    } gpmc_ctrl_t;

    // Bus released: all strobes inactive, AD not driven.
    localparam gpmc_ctrl_t CTRL_IDLE = '{csn: 1'b1, advn: 1'b1, wein: 1'b1, oen: 1'b1, ad_oe: 1'b0};

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/gpmc_sync_master_clk_div.sv
// Bus clock divider for the GPMC initiator.
//   clk       in  system clock
//   rst_n     in  asynchronous active-low reset
//   gpmc_clk  out divided clock, toggles every CLK_DIV clk cycles, 0 in reset
//   rise_tick out high during the clk cycle whose closing edge sets gpmc_clk to 1
module gpmc_sync_master_clk_div #(
    parameter int CLK_DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    output logic gpmc_clk,
    output logic rise_tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt;
    logic          wrap;

    assign wrap      = (cnt == CW'(CLK_DIV - 1));
    assign rise_tick = wrap & ~gpmc_clk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            gpmc_clk <= 1'b0;
        end else if (wrap) begin
            cnt      <= '0;
            gpmc_clk <= ~gpmc_clk;
        end else begin
            cnt      <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/gpmc_sync_master.sv
// Synchronous multiplexed 16-bit GPMC bus initiator.
// Converts single host requests into complete GPMC read/write cycles.
//   clk, rst_n            system clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake; req_we/req_addr/req_wdata request payload
//   resp_valid            one-clk pulse when a bus cycle finishes; resp_we echoes its direction
//   resp_rdata            read data, held until the next read finishes
//   gpmc_clk              free-running bus clock (clk / (2*CLK_DIV))
//   gpmc_csn/advn/wein/oen active-low bus strobes
//   gpmc_ad_out/ad_oe     AD drive value and drive enable (tri-state lives at the pad level)
//   gpmc_ad_in            AD pad value
//
// Handshake: a request transfers on a clk edge where req_valid && req_ready.
// req_ready is high only while idle with nothing pending; it drops on the
// accepting edge and the host must hold its request until it sees ready.
//
// All bus outputs are registered and only update on rise ticks, so they are
// stable around the gpmc_clk falling edge where the responder samples.
module gpmc_sync_master
    import gpmc_sync_master_pkg::*;
#(
    parameter int ADDR_WIDTH    = 16,
    parameter int DATA_WIDTH    = 16,
    parameter int CLK_DIV       = DEF_CLK_DIV,
    parameter int ADDR_CYCLES   = DEF_ADDR_CYCLES,
    parameter int ACCESS_CYCLES = DEF_ACCESS_CYCLES,
    parameter int TURN_CYCLES   = DEF_TURN_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic                  resp_we,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  gpmc_clk,
    output logic                  gpmc_csn,
    output logic                  gpmc_advn,
    output logic                  gpmc_wein,
    output logic                  gpmc_oen,
    output logic [AD_WIDTH-1:0]   gpmc_ad_out,
    output logic                  gpmc_ad_oe,
    input  logic [AD_WIDTH-1:0]   gpmc_ad_in
);

    localparam int MAXC = max2(max2(ADDR_CYCLES, ACCESS_CYCLES), max2(TURN_CYCLES, 1));
    localparam int PW   = $clog2(MAXC) + 1;

    logic                  rise_tick;
    logic                  accept;
    logic                  finish;
    logic                  phase_last;
    logic [PW-1:0]         phase_len;

    gpmc_state_e           state_q, state_d;
    logic [PW-1:0]         phase_q, phase_d;
    logic                  pend_q, pend_d;
    gpmc_ctrl_t            ctrl_q, ctrl_d;
    logic [AD_WIDTH-1:0]   ad_q, ad_d;

    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    gpmc_sync_master_clk_div #(
        .CLK_DIV   (CLK_DIV)
    ) u_clk_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .gpmc_clk  (gpmc_clk),
        .rise_tick (rise_tick)
    );

    assign accept = req_valid & req_ready;

    // Length of the current phase in gpmc_clk periods.
    always_comb begin
        phase_len = PW'(1);
        case (state_q)
            ST_ADDR:   phase_len = PW'(ADDR_CYCLES);
            ST_ACCESS: phase_len = PW'(ACCESS_CYCLES);
            ST_TURN:   phase_len = PW'(TURN_CYCLES);
            default:   phase_len = PW'(1);
        endcase
    end

    assign phase_last = (phase_q == phase_len - PW'(1));

    // Next state, phase counter and next bus drive.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        pend_d  = pend_q;
        ctrl_d  = ctrl_q;
        ad_d    = ad_q;
        finish  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    pend_d = 1'b1;
                end
                // A request accepted on this very edge waits for the following rise tick.
                if (rise_tick && pend_q) begin
                    state_d = ST_ADDR;
                    pend_d  = 1'b0;
                    phase_d = '0;
                end
            end
            ST_ADDR: begin
                if (rise_tick) begin
                    if (phase_last) begin
                        state_d = we_q ? ST_ACCESS : ST_RTURN;
                        phase_d = '0;
                    end else begin
                        phase_d = phase_q + PW'(1);
                    end
                end
            end
            ST_RTURN: begin
                if (rise_tick) begin
                    state_d = ST_ACCESS;
                    phase_d = '0;
                end
            end
            ST_ACCESS: begin
                if (rise_tick) begin
                    if (phase_last) begin
                        state_d = ST_TURN;
                        phase_d = '0;
                        finish  = 1'b1;
                    end else begin
                        phase_d = phase_q + PW'(1);
                    end
                end
            end
            ST_TURN: begin
                if (rise_tick) begin
                    if (phase_last) begin
                        state_d = ST_IDLE;
                        phase_d = '0;
                    end else begin
                        phase_d = phase_q + PW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                phase_d = '0;
            end
        endcase

        // Bus drive follows the state being entered (or kept) on each rise tick.
        if (rise_tick) begin
            ctrl_d = CTRL_IDLE;
            ad_d   = '0;
            case (state_d)
                ST_ADDR: begin
                    ctrl_d.csn   = 1'b0;
                    ctrl_d.advn  = 1'b0;
                    ctrl_d.ad_oe = 1'b1;
                    ad_d         = AD_WIDTH'(addr_q);
                end
                ST_RTURN: begin
                    ctrl_d.csn = 1'b0;
                end
                ST_ACCESS: begin
                    ctrl_d.csn = 1'b0;
                    if (we_q) begin
                        ctrl_d.wein  = 1'b0;
                        ctrl_d.ad_oe = 1'b1;
                        ad_d         = AD_WIDTH'(wdata_q);
                    end else begin
                        ctrl_d.oen = 1'b0;
                    end
                end
                default: begin
                    ctrl_d = CTRL_IDLE;
                    ad_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            phase_q <= '0;
            pend_q  <= 1'b0;
            ctrl_q  <= CTRL_IDLE;
            ad_q    <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            pend_q  <= pend_d;
            ctrl_q  <= ctrl_d;
            ad_q    <= ad_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

    // Ready returns one clk after settling in IDLE, and never on the edge leaving it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_we    <= 1'b0;
            resp_rdata <= '0;
        end else begin
            req_ready  <= (state_q == ST_IDLE) && (state_d == ST_IDLE) && !pend_d;
            resp_valid <= finish;
            if (finish) begin
                resp_we <= we_q;
                if (!we_q) begin
                    resp_rdata <= gpmc_ad_in[DATA_WIDTH-1:0];
                end
            end
        end
    end

    assign gpmc_csn    = ctrl_q.csn;
    assign gpmc_advn   = ctrl_q.advn;
    assign gpmc_wein   = ctrl_q.wein;
    assign gpmc_oen    = ctrl_q.oen;
    assign gpmc_ad_oe  = ctrl_q.ad_oe;
    assign gpmc_ad_out = ad_q;

endmodule
